// File: rtl/sim_run_ctrl_if.sv
// sim_run_ctrl_if: run-control bus between the simulation harness and the run controller
interface sim_run_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
);
    logic             start;
    logic [N_CH-1:0]  ch_done;
    logic [N_CH-1:0]  ch_act;
    logic             dut_rst_n;
    logic             heartbeat;
    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       state;
    logic [N_CH-1:0]  done_mask;
    logic             finish;
    logic             timeout;
    logic [N_CH-1:0]  stall;
    modport master (
        output start, ch_done, ch_act,
        input  dut_rst_n, heartbeat, cycle_cnt, state, done_mask, finish, timeout, stall
    );
    modport slave (
        input  start, ch_done, ch_act,
        output dut_rst_n, heartbeat, cycle_cnt, state, done_mask, finish, timeout, stall
    );
endinterface

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: simulation run sequencer (reset hold, run, completion/timeout); STALL_WDOG_EN adds per-channel stall watchdogs
module sim_run_ctrl #(
    parameter int N_CH        = 4,
    parameter int RST_CYC     = 100,
    parameter int HB_CYC      = 5000,
    parameter int TIMEOUT_CYC = 25000,
    parameter int CNT_W       = 32,
    parameter int STALL_CYC   = 1000
) (
    input logic           gm_clk,
    input logic           rst,
    sim_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_HOLD = 3'd1,
        RUN      = 3'd2,
        DONE     = 3'd3,
        TMO      = 3'd4
    } state_t;

    localparam int RST_W = $clog2(RST_CYC + 1);
    localparam int HB_W  = $clog2(HB_CYC);

    state_t           st;
    logic [RST_W-1:0] rst_cnt;
    logic [HB_W-1:0]  hb_cnt;
    logic [CNT_W-1:0] cnt;
    logic [N_CH-1:0]  dmask;
    logic [N_CH-1:0]  dnext;
    logic             rst_n_q;
    logic             hb;
    logic             fin;
    logic             tmo;

    assign dnext = dmask | bus.ch_done;

    // run sequencer; completion is checked before timeout so a same-cycle tie ends in DONE
    always_ff @(posedge gm_clk) begin
        if (rst) begin
            st      <= IDLE;
            rst_cnt <= '0;
            hb_cnt  <= '0;
            cnt     <= '0;
            dmask   <= '0;
            rst_n_q <= 1'b0;
            hb      <= 1'b0;
            fin     <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            hb <= 1'b0;
            case (st)
                IDLE: if (bus.start) st <= RST_HOLD;
                RST_HOLD: begin
                    if (rst_cnt == RST_W'(RST_CYC - 1)) begin
                        st      <= RUN;
                        rst_n_q <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    dmask <= dnext;
                    if (&dnext) begin
                        st  <= DONE;
                        fin <= 1'b1;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        st  <= TMO;
                        tmo <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt    <= cnt + 1'b1;
                        hb_cnt <= (hb_cnt == HB_W'(HB_CYC - 1)) ? '0 : hb_cnt + 1'b1;
                        hb     <= hb_cnt == HB_W'(HB_CYC - 2);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state     = st;
    assign bus.dut_rst_n = rst_n_q;
    assign bus.heartbeat = hb;
    assign bus.cycle_cnt = cnt;
    assign bus.done_mask = dmask;
    assign bus.finish    = fin;
    assign bus.timeout   = tmo;

`ifdef STALL_WDOG_EN
    localparam int STL_W = $clog2(STALL_CYC + 1);

    logic [STL_W-1:0] stl_cnt [N_CH];
    logic [N_CH-1:0]  stl;

    // per-channel inactivity watchdog; counts only while running and saturates at the limit
    always_ff @(posedge gm_clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                stl_cnt[i] <= '0;
                stl[i]     <= 1'b0;
            end else if (st == RUN) begin
                if (bus.ch_act[i] || dmask[i]) begin
                    stl_cnt[i] <= '0;
                end else if (stl_cnt[i] != STL_W'(STALL_CYC)) begin
                    stl_cnt[i] <= stl_cnt[i] + 1'b1;
                    if (stl_cnt[i] == STL_W'(STALL_CYC - 1)) stl[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.stall = stl;
`else
    assign bus.stall = '0;
`endif
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: vector table of run scenarios plus hand-written reset/stall sequences, heartbeat scoreboard
module tb_sim_run_ctrl;
    logic gm_clk = 1'b0;
    logic rst    = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   hbq [$];

`ifdef STALL_WDOG_EN
    localparam logic [1:0] STALL_EXP = 2'b10;
`else
    localparam logic [1:0] STALL_EXP = 2'b00;
`endif

    typedef struct {
        logic [1:0] d_a;
        int         t_a;
        logic [1:0] d_b;
        int         t_b;
        logic [2:0] st;
        logic       fin;
        logic       tmo;
        int         cnt;
        logic [1:0] mask;
    } vec_t;

    vec_t vecs [7];

    sim_run_ctrl_if #(.N_CH(2), .CNT_W(32)) bus ();

    sim_run_ctrl #(
        .N_CH(2), .RST_CYC(4), .HB_CYC(8), .TIMEOUT_CYC(40), .CNT_W(32), .STALL_CYC(6)
    ) dut (
        .gm_clk(gm_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 gm_clk = ~gm_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge gm_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.ch_done = 2'b00;
        bus.ch_act = 2'b11;
        step();
        rst = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_state"}, bus.state, 0);
        chk({tag, "_rst_n"}, bus.dut_rst_n, 0);
        chk({tag, "_hb"}, bus.heartbeat, 0);
        chk({tag, "_cnt"}, bus.cycle_cnt, 0);
        chk({tag, "_mask"}, bus.done_mask, 0);
        chk({tag, "_fin"}, bus.finish, 0);
        chk({tag, "_tmo"}, bus.timeout, 0);
        chk({tag, "_stall"}, bus.stall, 0);
    endtask

    task automatic start_run();
        int hold = 0;
        int n = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (bus.state == 3'd1 && n < 20) begin
            if (bus.dut_rst_n == 1'b0) hold++;
            n++;
            step();
        end
        chk("rst_hold_len", hold, 4);
        chk("run_state", bus.state, 2);
        chk("run_cnt0", bus.cycle_cnt, 0);
        chk("run_rst_n", bus.dut_rst_n, 1);
    endtask

    task automatic hb_mon();
        if (bus.heartbeat) begin
            if (hbq.size() == 0) chk("hb_extra", 1, 0);
            else chk("hb_at", bus.cycle_cnt, hbq.pop_front());
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k = 0;
        hbq.delete();
        do_reset();
        start_run();
        while (bus.state == 3'd2 && k < 60) begin
            if (k % 8 == 7 && k <= v.cnt) hbq.push_back(k);
            chk("cnt_track", bus.cycle_cnt, k);
            hb_mon();
            bus.ch_done = (k == v.t_a ? v.d_a : 2'b00) | (k == v.t_b ? v.d_b : 2'b00);
            step();
            k++;
        end
        bus.ch_done = 2'b00;
        chk("run_bound", k < 60, 1);
        hb_mon();
        chk("hb_missing", hbq.size(), 0);
        chk("end_state", bus.state, v.st);
        chk("end_finish", bus.finish, v.fin);
        chk("end_timeout", bus.timeout, v.tmo);
        chk("end_cnt", bus.cycle_cnt, v.cnt);
        chk("end_mask", bus.done_mask, v.mask);
        chk("end_rst_n", bus.dut_rst_n, 1);
        chk("end_hb", bus.heartbeat, 0);
        bus.start = 1'b1;
        bus.ch_done = 2'b11;
        repeat (3) step();
        bus.start = 1'b0;
        bus.ch_done = 2'b00;
        chk("term_state", bus.state, v.st);
        chk("term_cnt", bus.cycle_cnt, v.cnt);
        chk("term_mask", bus.done_mask, v.mask);
        chk("term_excl", bus.finish & bus.timeout, 0);
    endtask

    initial begin
        vecs[0] = '{2'b00, -1, 2'b00, -1, 3'd4, 1'b0, 1'b1, 39, 2'b00};
        vecs[1] = '{2'b01,  5, 2'b10, 12, 3'd3, 1'b1, 1'b0, 12, 2'b11};
        vecs[2] = '{2'b11, 39, 2'b00, -1, 3'd3, 1'b1, 1'b0, 39, 2'b11};
        vecs[3] = '{2'b11,  0, 2'b00, -1, 3'd3, 1'b1, 1'b0,  0, 2'b11};
        vecs[4] = '{2'b10, 20, 2'b00, -1, 3'd4, 1'b0, 1'b1, 39, 2'b10};
        vecs[5] = '{2'b01, 38, 2'b10, 38, 3'd3, 1'b1, 1'b0, 38, 2'b11};
        vecs[6] = '{2'b01, 39, 2'b00, -1, 3'd4, 1'b0, 1'b1, 39, 2'b01};

        do_reset();
        reset_vals("init");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        do_reset();
        start_run();
        repeat (3) step();
        bus.ch_done = 2'b01;
        step();
        bus.ch_done = 2'b00;
        repeat (16) step();
        chk("pre_rst_cnt", bus.cycle_cnt, 20);
        chk("pre_rst_mask", bus.done_mask, 1);
        rst = 1'b1;
        step();
        reset_vals("midrun");
        rst = 1'b0;
        start_run();
        chk("post_rst_mask", bus.done_mask, 0);

        do_reset();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("hold_entered", bus.state, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_vals("midhold");
        step();
        chk("idle_stays", bus.state, 0);
        start_run();

        do_reset();
        bus.ch_done = 2'b11;
        repeat (3) step();
        chk("idle_ign_state", bus.state, 0);
        chk("idle_ign_mask", bus.done_mask, 0);
        bus.ch_done = 2'b00;
        start_run();
        bus.start = 1'b1;
        repeat (5) step();
        bus.start = 1'b0;
        chk("run_ign_start", bus.state, 2);
        chk("run_ign_cnt", bus.cycle_cnt, 5);

        do_reset();
        bus.ch_act = 2'b01;
        start_run();
        repeat (5) step();
        chk("stall_pre", bus.stall, 0);
        step();
        chk("stall_set", bus.stall, STALL_EXP);
        chk("stall_state", bus.state, 2);
        step();
        chk("stall_sticky", bus.stall, STALL_EXP);
        bus.ch_act = 2'b11;
        step();
        chk("stall_hold", bus.stall, STALL_EXP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
